ccg_sweep_ctrl: RTL

Exhaustive sweep controller for the team's CCG benchmark netlists: combinational, 9 inputs `x0..x8`, 11 outputs `f1..f11`. It owns the circuit-under-test (CUT) inputs, steps through all 2^N_IN input vectors, and waits a programmable settle time per vector. Each vector's outputs are folded into a 16-bit MISR signature and a set-bit total, and the result is presented to the host through a valid/ready handshake. It sits between the host testbench/harness and one ABC-generated CUT instance, and is used to characterise or check original vs. balanced netlists.

---
 rtl/ccg_sweep_pkg.sv | 34 +++
 rtl/ccg_misr16.sv | 33 +++
 rtl/ccg_sweep_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ccg_sweep_pkg.sv
// Shared types and helpers for the CCG exhaustive sweep controller.
//   sweep_state_t : controller FSM states
//   MISR_POLY     : feedback taps of the 16-bit signature register
//   MISR_SEED     : signature value at the start of every run
//   misr_step()   : one signature update with a 16-bit data word
//   popcount()    : number of set bits in a 16-bit word
package ccg_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_REPORT = 2'd3
   } sweep_state_t;

   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam logic [15:0] MISR_SEED = 16'hFFFF;

   function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] data);
      logic [15:0] fb;
      fb = sig[15] ? MISR_POLY : 16'h0000;
      return {sig[14:0], 1'b0} ^ fb ^ data;
   endfunction

   function automatic logic [4:0] popcount(input logic [15:0] data);
      logic [4:0] cnt;
      cnt = '0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'b0000, data[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/ccg_misr16.sv
// 16-bit multiple-input signature register.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset, loads the seed
//   clr_i  : synchronous reload of the seed (start of a run)
//   en_i   : fold data_i into the signature on this edge
//   data_i : 16-bit word to compress
//   sig_o  : current signature
module ccg_misr16
   import ccg_sweep_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [15:0] data_i,
   output logic [15:0] sig_o
);

   logic [15:0] sig_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= MISR_SEED;
      end else if (clr_i) begin
         sig_q <= MISR_SEED;
      end else if (en_i) begin
         sig_q <= misr_step(sig_q, data_i);
      end
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/ccg_sweep_ctrl.sv
// Exhaustive sweep controller for a combinational CCG benchmark netlist.
// Drives every input vector 0 .. 2^N_IN-1 onto the CUT, holds each for SETTLE
// cycles, then folds the CUT outputs into a MISR signature and a set-bit total.
// The result is offered to the host with a valid/ready handshake.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : level, accepted only in IDLE (also latches exp_sig)
//   abort             : level, returns any non-IDLE state to IDLE
//   exp_sig[15:0]     : golden signature
//   cut_x[N_IN-1:0]   : vector driven to the CUT
//   cut_f[N_OUT-1:0]  : CUT outputs (N_OUT <= 16)
//   busy              : sweep in progress
//   result_valid      : result presented (REPORT)
//   result_ready      : host accepts result
//   signature[15:0]   : MISR value
//   ones_total        : sum of popcount(cut_f) over all samples
//   pass              : signature matches latched exp_sig, while result_valid
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | waiting for start; cut_x holds last vector
// ST_DRIVE  | current vector on cut_x, counting settle cycles
// ST_SAMPLE | cut_f folded into signature/total on this edge
// ST_REPORT | result frozen until result_ready
module ccg_sweep_ctrl
   import ccg_sweep_pkg::*;
#(
   parameter int N_IN   = 9,
   parameter int N_OUT  = 11,
   parameter int SETTLE = 2,
   parameter int CNT_W  = $clog2((2 ** N_IN) * N_OUT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [15:0]       exp_sig,
   output logic [N_IN-1:0]   cut_x,
   input  logic [N_OUT-1:0]  cut_f,
   output logic              busy,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [15:0]       signature,
   output logic [CNT_W-1:0]  ones_total,
   output logic              pass
);

   localparam int                SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE - 1);
   // One extra bit so the vector counter can never wrap back into range.
   localparam logic [N_IN:0]     VEC_LAST = (N_IN + 1)'((2 ** N_IN) - 1);

   sweep_state_t        state_q;
   logic [N_IN:0]       vec_q;
   logic [SET_W-1:0]    settle_q;
   logic [CNT_W-1:0]    ones_q;
   logic [CNT_W-1:0]    ones_d;
   logic [15:0]         exp_q;
   logic [15:0]         misr_data;
   logic [4:0]          pop;
   logic                misr_clr;
   logic                misr_en;
   logic [15:0]         sig;

   assign misr_data = 16'(cut_f);
   assign pop       = popcount(misr_data);
   assign ones_d    = ones_q + CNT_W'(pop);

   // Abort wins over a pending sample so partial results stay untouched.
   assign misr_clr  = (state_q == ST_IDLE) && start;
   assign misr_en   = (state_q == ST_SAMPLE) && !abort;

   ccg_misr16 u_misr (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (misr_clr),
      .en_i   (misr_en),
      .data_i (misr_data),
      .sig_o  (sig)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         vec_q    <= '0;
         settle_q <= '0;
         ones_q   <= '0;
         exp_q    <= '0;
      end else if (abort && (state_q != ST_IDLE)) begin
         state_q  <= ST_IDLE;
         settle_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  vec_q    <= '0;
                  settle_q <= '0;
                  ones_q   <= '0;
                  exp_q    <= exp_sig;
                  state_q  <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               if (settle_q == SET_LAST) begin
                  settle_q <= '0;
                  state_q  <= ST_SAMPLE;
               end else begin
                  settle_q <= settle_q + SET_W'(1);
               end
            end
            ST_SAMPLE: begin
               ones_q <= ones_d;
               if (vec_q == VEC_LAST) begin
                  state_q <= ST_REPORT;
               end else begin
                  vec_q   <= vec_q + (N_IN + 1)'(1);
                  state_q <= ST_DRIVE;
               end
            end
            ST_REPORT: begin
               if (result_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cut_x        = vec_q[N_IN-1:0];
   assign busy         = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
   assign result_valid = (state_q == ST_REPORT);
   assign signature    = sig;
   assign ones_total   = ones_q;
   assign pass         = (state_q == ST_REPORT) && (sig == exp_q);

endmodule
